// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring DIV/DIVU unit for the EX stage
// Optional macro DIV_RESULT_HOLD_EN: result holds the last completed value instead of reading 0 outside END.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall,
  output logic                 div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   abs1, abs2, rem_step, quo_step;
  logic [WIDTH:0]     shifted, trial;

  // quo_q doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    abs1     = (signed_div && num1[WIDTH-1]) ? -num1 : num1;
    abs2     = (signed_div && num2[WIDTH-1]) ? -num2 : num2;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted + {1'b1, ~dvsr_q} + {{WIDTH{1'b0}}, 1'b1};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_d     = res_q;
    stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          stall     = 1'b1;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = abs1;
          dvsr_d    = abs2;
          neg_quo_d = signed_div & (num1[WIDTH-1] ^ num2[WIDTH-1]);
          neg_rem_d = signed_div & num1[WIDTH-1];
          dz_d      = 1'b0;
          state_d   = (num2 == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        stall = 1'b1;
        if (annul) begin
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          res_d   = '0;
          dz_d    = 1'b1;
          state_d = S_END;
        end
      end
      S_ON: begin
        stall = 1'b1;
        if (annul) begin
          dz_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            res_d   = {neg_rem_q ? -rem_step : rem_step,
                       neg_quo_q ? -quo_step : quo_step};
            dz_d    = 1'b0;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (annul) dz_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      res_q     <= res_d;
    end
  end

  assign ready    = (state_q == S_END);
  assign div_zero = dz_q;

`ifdef DIV_RESULT_HOLD_EN
  assign result = res_q;
`else
  assign result = ready ? res_q : '0;
`endif

endmodule
